// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core data
// port (C) and a DMA / program-loader port (D). One grant per cycle,
// round-robin on contention, bounded burst lock for D, registered read
// return to the winning port with a latency of one cycle.
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                clk,
    input  logic                reset_n,

    // core data port
    input  logic                c_req,
    input  logic [DATA_W/8-1:0] c_we,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_wdata,
    output logic                c_gnt,
    output logic                c_stall,
    output logic                c_rvalid,
    output logic [DATA_W-1:0]   c_rdata,

    // DMA / loader port
    input  logic                d_req,
    input  logic [DATA_W/8-1:0] d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic                d_lock,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,

    // memory side
    output logic [DATA_W/8-1:0] m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int         BE_W        = DATA_W / 8;
    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_e;

    state_e            state_q, state_d;
    port_e             last_q, last_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;

    logic              c_rvalid_q, c_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic              lock_hold;
    logic              c_first;
    logic              c_win;
    logic              d_win;

    // Arbitration: grants, next state, round-robin pointer and burst count.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves it unassigned; a missed branch would otherwise infer a latch.
        state_d     = ARB;
        last_d      = last_q;
        burst_cnt_d = '0;
        c_win       = 1'b0;
        d_win       = 1'b0;
        c_first     = 1'b0;

        // D keeps the memory while it holds the lock and has beats left.
        lock_hold = (state_q == LOCK) && d_req && d_lock &&
                    (burst_cnt_q < MAX_BURST_C);

        if (lock_hold) begin
            d_win       = 1'b1;
            state_d     = LOCK;
            last_d      = PORT_D;
            burst_cnt_d = burst_cnt_q + 8'd1;
        end else begin
            // Leaving a lock arbitrates as if D had the last grant, so the
            // core wins any contention on the release cycle.
            c_first = (state_q == LOCK) || (last_q == PORT_D);

            if (c_req && (!d_req || c_first)) begin
                c_win = 1'b1;
            end else if (d_req) begin
                d_win = 1'b1;
            end

            if (c_win) begin
                last_d = PORT_C;
            end

            if (d_win) begin
                last_d = PORT_D;
                if (d_lock) begin
                    state_d     = LOCK;
                    burst_cnt_d = 8'd1;
                end
            end
        end
    end

    // Memory drive: winner's address/data/lanes; idle keeps port C's values.
    always_comb begin
        m_addr  = d_win ? d_addr  : c_addr;
        m_wdata = d_win ? d_wdata : c_wdata;
        m_we    = '0;
        if (c_win) begin
            m_we = c_we;
        end else if (d_win) begin
            m_we = d_we;
        end
    end

    // Read return: capture memory data for a granted read, else hold.
    always_comb begin
        c_rvalid_d = c_win && (c_we == '0);
        d_rvalid_d = d_win && (d_we == '0);
        c_rdata_d  = c_rvalid_d ? m_rdata : c_rdata_q;
        d_rdata_d  = d_rvalid_d ? m_rdata : d_rdata_q;
    end

    // State and read-return registers; reset returns to ARB with core priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB;
            last_q      <= PORT_D;
            burst_cnt_q <= '0;
            c_rvalid_q  <= 1'b0;
            d_rvalid_q  <= 1'b0;
            c_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge value of the others, independent of statement order.
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            c_rvalid_q  <= c_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            c_rdata_q   <= c_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign c_gnt    = c_win;
    assign d_gnt    = d_win;
    assign c_stall  = c_req & ~c_win;
    assign c_rvalid = c_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign c_rdata  = c_rdata_q;
    assign d_rdata  = d_rdata_q;

    // Byte-lane count is part of the interface contract; keep it referenced.
    logic be_w_ok;
    assign be_w_ok = (BE_W * 8 == DATA_W);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, a reset-mid-lock sequence and a
// randomized run, all compared against a behavioural arbiter/memory model.
module tb_dmem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 8;

    logic        clk;
    logic        reset_n;
    logic        c_req, d_req, d_lock;
    logic [3:0]  c_we, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic [3:0]  m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_gnt   (c_gnt),
        .c_stall (c_stall),
        .c_rvalid(c_rvalid),
        .c_rdata (c_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_lock  (d_lock),
        .d_gnt   (d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata (d_rdata),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory attached to the DUT ----------------
    function automatic logic [31:0] init_val(input logic [7:0] a);
        if (a == 8'h10) return 32'hDEAD_BEEF;
        return {a, ~a, a ^ 8'h5A, 8'hC3};
    endfunction

    logic [31:0] mem    [256];
    bit          mem_wr [256];

    assign m_rdata = mem_wr[m_addr[7:0]] ? mem[m_addr[7:0]] : init_val(m_addr[7:0]);

    always @(posedge clk) begin
        if (m_we != 4'b0000) begin
            logic [31:0] w;
            w = m_rdata;
            for (int b = 0; b < 4; b++)
                if (m_we[b]) w[b*8 +: 8] = m_wdata[b*8 +: 8];
            mem[m_addr[7:0]]    <= w;
            mem_wr[m_addr[7:0]] <= 1'b1;
        end
    end

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic        c_req;
        logic [3:0]  c_we;
        logic [31:0] c_addr;
        logic [31:0] c_wdata;
        logic        d_req;
        logic [3:0]  d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        d_lock;
        logic        exp_c_gnt;
        logic        exp_d_gnt;
    } vec_t;

    bit          ref_core_first;   // core wins the next contention
    int          ref_burst;        // locked D beats in the current run
    logic [31:0] ref_mem [256];
    logic        exp_c_rvalid, exp_d_rvalid;
    logic [31:0] exp_c_rdata, exp_d_rdata;

    function automatic vec_t mk(input logic cr, input logic [3:0] cwe,
                                input logic [31:0] ca, input logic [31:0] cwd,
                                input logic dr, input logic [3:0] dwe,
                                input logic [31:0] da, input logic [31:0] dwd,
                                input logic dl, input logic ecg, input logic edg);
        vec_t v;
        v.c_req = cr;  v.c_we = cwe; v.c_addr = ca; v.c_wdata = cwd;
        v.d_req = dr;  v.d_we = dwe; v.d_addr = da; v.d_wdata = dwd;
        v.d_lock = dl; v.exp_c_gnt = ecg; v.exp_d_gnt = edg;
        return v;
    endfunction

    task automatic model_reset();
        ref_core_first = 1'b1;
        ref_burst      = 0;
        exp_c_rvalid   = 1'b0;
        exp_d_rvalid   = 1'b0;
        exp_c_rdata    = '0;
        exp_d_rdata    = '0;
    endtask

    // Who should win this cycle, from the arbitration rules.
    function automatic void model_grant(input vec_t v, output bit wc,
                                        output bit wd, output bit keep);
        bit core_first;
        wc   = 1'b0;
        wd   = 1'b0;
        keep = (ref_burst > 0) && v.d_req && v.d_lock && (ref_burst < MAX_BURST);
        if (keep) begin
            wd = 1'b1;
        end else begin
            core_first = (ref_burst > 0) || ref_core_first;
            if (v.c_req && (!v.d_req || core_first)) wc = 1'b1;
            else if (v.d_req)                         wd = 1'b1;
        end
    endfunction

    task automatic model_update(input vec_t v, input bit wc, input bit wd, input bit keep);
        logic [3:0]  we;
        logic [7:0]  idx;
        logic [31:0] data;
        we   = wc ? v.c_we : (wd ? v.d_we : 4'b0000);
        idx  = wd ? v.d_addr[7:0] : v.c_addr[7:0];
        data = wd ? v.d_wdata : v.c_wdata;

        exp_c_rvalid = wc && (v.c_we == 4'b0000);
        exp_d_rvalid = wd && (v.d_we == 4'b0000);
        if (exp_c_rvalid) exp_c_rdata = ref_mem[idx];
        if (exp_d_rvalid) exp_d_rdata = ref_mem[idx];

        for (int b = 0; b < 4; b++)
            if (we[b]) ref_mem[idx][b*8 +: 8] = data[b*8 +: 8];

        if (wc) ref_core_first = 1'b0;
        if (wd) ref_core_first = 1'b1;

        if (keep)                ref_burst = ref_burst + 1;
        else if (wd && v.d_lock) ref_burst = 1;
        else                     ref_burst = 0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, check before the rising edge.
    task automatic step(input vec_t v, input bit use_tbl, input string tag);
        bit wc, wd, keep;
        c_req = v.c_req; c_we = v.c_we; c_addr = v.c_addr; c_wdata = v.c_wdata;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
        d_lock = v.d_lock;
        #1;
        model_grant(v, wc, wd, keep);
        if (use_tbl) begin
            check($sformatf("%s c_gnt(table)", tag), {31'b0, c_gnt}, {31'b0, v.exp_c_gnt});
            check($sformatf("%s d_gnt(table)", tag), {31'b0, d_gnt}, {31'b0, v.exp_d_gnt});
        end
        check($sformatf("%s c_gnt", tag),    {31'b0, c_gnt},    {31'b0, wc});
        check($sformatf("%s d_gnt", tag),    {31'b0, d_gnt},    {31'b0, wd});
        check($sformatf("%s c_stall", tag),  {31'b0, c_stall},  {31'b0, v.c_req && !wc});
        check($sformatf("%s m_we", tag),     {28'b0, m_we},
              {28'b0, (wc ? v.c_we : (wd ? v.d_we : 4'b0000))});
        check($sformatf("%s m_addr", tag),   m_addr,  wd ? v.d_addr  : v.c_addr);
        check($sformatf("%s m_wdata", tag),  m_wdata, wd ? v.d_wdata : v.c_wdata);
        check($sformatf("%s c_rvalid", tag), {31'b0, c_rvalid}, {31'b0, exp_c_rvalid});
        check($sformatf("%s d_rvalid", tag), {31'b0, d_rvalid}, {31'b0, exp_d_rvalid});
        check($sformatf("%s c_rdata", tag),  c_rdata, exp_c_rdata);
        check($sformatf("%s d_rdata", tag),  d_rdata, exp_d_rdata);
        @(posedge clk);
        model_update(v, wc, wd, keep);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        c_req = 1'b0; c_we = '0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;
    endtask

    // Hard stop if the run ever stalls.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    vec_t vecs[22];

    initial begin
        vec_t v;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        model_reset();
        idle_inputs();
        reset_n = 1'b0;

        // Directed table, applied from reset (core has priority first).
        vecs[0]  = mk(1, 4'h0, 32'h10, 32'h0,         0, 4'h0, 32'h0,  32'h0, 0, 1, 0);
        vecs[1]  = mk(0, 4'h0, 32'h0,  32'h0,         1, 4'h0, 32'h11, 32'h0, 0, 0, 1);
        vecs[2]  = mk(1, 4'hF, 32'h30, 32'h1111_1111, 1, 4'h0, 32'h13, 32'h0, 0, 1, 0);
        vecs[3]  = mk(1, 4'hF, 32'h30, 32'h2222_2222, 1, 4'h0, 32'h13, 32'h0, 0, 0, 1);
        vecs[4]  = mk(1, 4'hF, 32'h30, 32'h3333_3333, 1, 4'h0, 32'h13, 32'h0, 0, 1, 0);
        vecs[5]  = mk(1, 4'hF, 32'h30, 32'h4444_4444, 1, 4'h0, 32'h13, 32'h0, 0, 0, 1);
        vecs[6]  = mk(1, 4'h2, 32'h20, 32'h0000_AB00, 0, 4'h0, 32'h0,  32'h0, 0, 1, 0);
        vecs[7]  = mk(1, 4'h0, 32'h20, 32'h0,         0, 4'h0, 32'h0,  32'h0, 0, 1, 0);
        for (int i = 8; i <= 19; i++) begin
            // 8 locked D beats, forced release to C, then D re-locks
            vecs[i] = mk(1, 4'h0, 32'h15, 32'h0, 1, 4'h0, 32'h14, 32'h0, 1,
                         (i == 16), (i != 16));
        end
        // lock dropped after 3 re-locked beats: C wins the 4th cycle
        vecs[20] = mk(1, 4'h0, 32'h15, 32'h0, 1, 4'h0, 32'h14, 32'h0, 0, 1, 0);
        vecs[21] = mk(0, 4'h0, 32'h0,  32'h0, 0, 4'h0, 32'h0,  32'h0, 0, 0, 0);

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("reset c_gnt",    {31'b0, c_gnt},    32'h0);
        check("reset d_gnt",    {31'b0, d_gnt},    32'h0);
        check("reset c_rvalid", {31'b0, c_rvalid}, 32'h0);
        check("reset d_rvalid", {31'b0, d_rvalid}, 32'h0);
        check("reset c_rdata",  c_rdata, 32'h0);
        check("reset d_rdata",  d_rdata, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 22; i++) step(vecs[i], 1'b1, $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a lock with a read outstanding.
        v = mk(1, 4'h0, 32'h15, 32'h0, 1, 4'h0, 32'h16, 32'h0, 1, 0, 1);
        step(v, 1'b1, "lockA");
        step(v, 1'b1, "lockB");
        check("pre-reset d_rvalid", {31'b0, d_rvalid}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async c_rvalid", {31'b0, c_rvalid}, 32'h0);
        check("async d_rvalid", {31'b0, d_rvalid}, 32'h0);
        check("async d_rdata",  d_rdata, 32'h0);
        idle_inputs();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        v = mk(1, 4'h0, 32'h17, 32'h0, 1, 4'h0, 32'h18, 32'h0, 0, 1, 0);
        step(v, 1'b1, "post-reset");
        v = mk(1, 4'h0, 32'h17, 32'h0, 1, 4'h0, 32'h18, 32'h0, 0, 0, 1);
        step(v, 1'b1, "post-reset2");

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            v.c_req   = ($urandom % 4) != 0;
            v.c_we    = (($urandom % 2) == 0) ? 4'h0 : 4'($urandom);
            v.c_addr  = 32'($urandom % 16);
            v.c_wdata = $urandom;
            v.d_req   = ($urandom % 3) != 0;
            v.d_we    = (($urandom % 2) == 0) ? 4'h0 : 4'($urandom);
            v.d_addr  = 32'($urandom % 16);
            v.d_wdata = $urandom;
            v.d_lock  = ($urandom % 4) != 0;
            v.exp_c_gnt = 1'b0;
            v.exp_d_gnt = 1'b0;
            step(v, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory between the pipelined core's data port (port C) and a DMA/program-loader port (port D). It grants one request per cycle and drives the memory address, write data and byte-write-enable lanes. It registers the memory read data and returns it to the winning port one cycle later, and raises a core stall when the core loses arbitration. Contention is resolved round-robin; port D may lock the memory for a bounded burst.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (byte lanes = DATA_W/8)
MAX_BURST, 8, max consecutive locked grants to port D (range 1..255)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
c_req  in  1  core memory request (read or write)
c_we  in  DATA_W/8  core byte write enables; 0 = read
c_addr  in  ADDR_W  core address
c_wdata  in  DATA_W  core write data
c_gnt  out  1  core request accepted this cycle
c_stall  out  1  c_req & ~c_gnt (freezes core pipeline)
c_rvalid  out  1  core read data valid
c_rdata  out  DATA_W  core read data
d_req  in  1  DMA request
d_we  in  DATA_W/8  DMA byte write enables; 0 = read
d_addr  in  ADDR_W  DMA address
d_wdata  in  DATA_W  DMA write data
d_lock  in  1  request burst lock (held with d_req)
d_gnt  out  1  DMA request accepted this cycle
d_rvalid  out  1  DMA read data valid
d_rdata  out  DATA_W  DMA read data
m_we  out  DATA_W/8  memory byte write enables
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_rdata  in  DATA_W  memory read data (combinational from m_addr)

Behaviour:
- Reset (async, reset_n=0): state=ARB, last=D (core wins first contention), burst_cnt=0; c_rvalid, d_rvalid, c_rdata, d_rdata = 0. Grants are combinational and are therefore 0 while inputs idle.
- Grant logic is combinational from the current state and requests. At most one of c_gnt/d_gnt is high. A grant is never given without the matching req.
- State ARB:
  - Only one req high: grant that port.
  - Both high: grant the port != last.
  - On any grant, last <= the granted port.
  - If d_gnt & d_lock: go to LOCK, burst_cnt <= 1.
- State LOCK:
  - If d_req & d_lock & burst_cnt < MAX_BURST: d_gnt=1, c_gnt=0, burst_cnt++.
  - Otherwise exit to ARB in the same cycle and arbitrate that cycle as ARB with last=D, so the core wins contention.
  - At burst_cnt == MAX_BURST, the lock is force-released for one cycle even if d_lock is still high. If c_req is low that cycle, D may re-enter LOCK with burst_cnt <= 1.
- Memory drive:
  - m_addr/m_wdata follow the granted port; m_we = granted port's we.
  - With no grant: m_we=0, m_addr/m_wdata hold port C values (don't-care, but stable).
  - Writes never occur without a grant.
- Read return:
  - A granted read (we==0) registers m_rdata into x_rdata and pulses x_rvalid=1 on the next cycle (latency 1), for x = c or d.
  - Granted writes produce no rvalid.
  - Back-to-back reads give rvalid every cycle.
  - x_rdata holds its last value when rvalid=0.
- A request must be held stable until granted; the arbiter keeps no request queue.
- Reset mid-burst returns to ARB immediately and clears any pending rvalid.

Test Plan:
- Reset, then c_req read addr 0x10 with mem[0x10]=0xDEADBEEF -> c_gnt=1 same cycle, next cycle c_rvalid=1 and c_rdata=0xDEADBEEF; c_stall=0.
- c_req and d_req high for 4 cycles, no lock -> grants alternate C,D,C,D; c_stall=1 on D cycles; m_we matches the winner each cycle.
- Core write c_we=4'b0010 addr 0x20 data 0x0000AB00 -> m_we=4'b0010, only byte 1 of mem[0x20] changes; no c_rvalid.
- d_lock held with d_req and c_req for 12 cycles, MAX_BURST=8 -> d_gnt for 8 cycles, c_gnt on cycle 9, then d re-locks; c_stall high cycles 1-8.
- d_lock burst, d_lock dropped after 3 beats with c_req high -> 3 D grants, C granted on the 4th cycle.
- Assert reset_n=0 asynchronously mid-lock with a read outstanding -> all rvalid=0 immediately. After release, contention grants C first.
